sext_arbiter: RTL

Two-port arbiter and sequencer for the processor's single immediate-extension resource. It shares one sign/zero-extend datapath between the decode stage (port 0) and the branch/address unit (port 1) using round-robin arbitration. Each accepted request is extended and held in a one-entry output register with valid/ready backpressure, and the result is tagged with the winning port. It sits between the two requesters and the ALU operand mux.

---
 rtl/sext_arbiter.sv | 81 ++++++++
 1 files changed

// File: rtl/sext_arbiter.sv
// Round-robin arbiter sharing one immediate sign/zero-extend datapath between two
// requesters, with a one-entry valid/ready output register tagged by source port.
//
// state | meaning
// EMPTY | result register holds nothing
// FULL  | result register holds a result awaiting out_ready
module sext_arbiter #(
    parameter bit RR_RESET = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [8:0]  req0_imm,
    input  logic [1:0]  req0_sel,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [8:0]  req1_imm,
    input  logic [1:0]  req1_sel,
    output logic        req1_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_src
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]  state;
    logic        rr_ptr;
    logic        slot_free;
    logic        has_winner;
    logic        winner;
    logic        accept;
    logic [8:0]  win_imm;
    logic [1:0]  win_sel;
    logic [15:0] win_ext;

    function automatic logic [15:0] ext(input logic [8:0] imm, input logic [1:0] sel);
        case (sel)
            2'b00:   ext = {{7{imm[8]}}, imm};
            2'b01:   ext = {{8{imm[7]}}, imm[7:0]};
            2'b10:   ext = {{11{imm[4]}}, imm[4:0]};
            default: ext = {7'b0, imm};
        endcase
    endfunction

    // Readys are forced low during reset so nothing is handshaken into a clearing slot.
    always_comb begin
        slot_free  = ((state == EMPTY) | out_ready) & ~rst;
        has_winner = req0_valid | req1_valid;
        winner     = (req0_valid & req1_valid) ? rr_ptr : req1_valid;
        accept     = has_winner & slot_free;
        req0_ready = accept & (winner == 1'b0);
        req1_ready = accept & (winner == 1'b1);
        win_imm    = winner ? req1_imm : req0_imm;
        win_sel    = winner ? req1_sel : req0_sel;
        win_ext    = ext(win_imm, win_sel);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            rr_ptr   <= RR_RESET;
            out_data <= 16'h0000;
            out_src  <= 1'b0;
        end else begin
            if (accept) begin
                state    <= FULL;
                rr_ptr   <= ~winner;
                out_data <= win_ext;
                out_src  <= winner;
            end else if (out_ready) begin
                state <= EMPTY;
            end
        end
    end

    assign out_valid = (state == FULL);

endmodule
